// File: rtl/drive_bank_seq.sv
// -----------------------------------------------------------------------------
// drive_bank_seq
//   Ramps a set of switchable buffer/inverter drive banks up or down to a
//   requested level. Exactly one bank changes per step, and consecutive steps
//   are staggered by a programmable number of idle cycles. This limits the
//   di/dt seen by the supply when drive strength changes.
//
// Ports
//   CLK        in   rising-edge clock
//   RESETN     in   asynchronous active-low reset
//   req_valid  in   new target-level request
//   req_ready  out  request can be accepted this cycle
//   req_level  in   target number of enabled banks (clamped to NBANK)
//   req_dly    in   stagger cycles inserted between bank steps
//   force_off  in   emergency disable: all banks off at the next edge
//   bank_en    out  thermometer-coded bank enables (bit 0 first on, last off)
//   cur_level  out  number of enabled banks
//   busy       out  ramp in progress
//   done       out  one-cycle pulse on request completion
//   abort      out  one-cycle pulse when force_off cancels a ramp
// -----------------------------------------------------------------------------
module drive_bank_seq #(
  parameter int NBANK = 8,
  parameter int DLY_W = 8
) (
  input  logic                       CLK,
  input  logic                       RESETN,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [$clog2(NBANK+1)-1:0] req_level,
  input  logic [DLY_W-1:0]           req_dly,
  input  logic                       force_off,
  output logic [NBANK-1:0]           bank_en,
  output logic [$clog2(NBANK+1)-1:0] cur_level,
  output logic                       busy,
  output logic                       done,
  output logic                       abort
);

  localparam int LW = $clog2(NBANK+1);
  localparam logic [LW-1:0] NB = LW'(NBANK);

  typedef enum logic [1:0] {IDLE, STEP, WAIT} state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [NBANK-1:0]  r_bank;
  logic [LW-1:0]     r_level;
  logic [LW-1:0]     r_target;
  logic [DLY_W-1:0]  r_dly;
  logic [DLY_W-1:0]  r_cnt;
  logic              r_armed;
  logic              r_busy;
  logic              r_done_pend;
  logic              r_done;
  logic              r_abort_pend;
  logic              r_abort;

  logic              w_accept;
  logic [LW-1:0]     w_clamp;
  logic              w_up;
  logic [LW-1:0]     w_level_step;
  logic [NBANK-1:0]  w_bank_step;
  logic [DLY_W-1:0]  w_cnt_inc;
  logic              w_do_step;
  logic              w_finish;

  // r_armed keeps req_ready low until the first edge after reset release.
  assign req_ready = r_armed && (r_state == IDLE) && !force_off;
  assign w_accept  = req_valid && req_ready;
  assign w_clamp   = (req_level > NB) ? NB : req_level;

  // Because bank_en is thermometer coded, a shift adds or removes exactly the
  // bank at the boundary: shift-in a one to enable bit cur_level, shift right
  // to drop the highest enabled bank.
  assign w_up         = (r_target > r_level);
  assign w_level_step = w_up ? (r_level + 1'b1) : (r_level - 1'b1);
  assign w_bank_step  = w_up ? {r_bank[NBANK-2:0], 1'b1} : {1'b0, r_bank[NBANK-1:1]};
  assign w_cnt_inc    = r_cnt + 1'b1;

  // State register
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and step control
  always_comb begin
    w_state_next = r_state;
    w_do_step    = 1'b0;
    w_finish     = 1'b0;
    if (force_off) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_clamp != r_level) begin
              w_state_next = STEP;
            end else begin
              w_finish = 1'b1;
            end
          end
        end
        STEP: begin
          w_do_step = 1'b1;
          if (w_level_step == r_target) begin
            w_state_next = IDLE;
            w_finish     = 1'b1;
          end else if (r_dly == '0) begin
            w_state_next = STEP;
          end else begin
            w_state_next = WAIT;
          end
        end
        WAIT: begin
          // The counter runs 0..dly-1, so WAIT lasts exactly dly cycles and
          // never needs to count past dly.
          if (w_cnt_inc == r_dly) begin
            w_state_next = STEP;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Datapath and status registers
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_bank       <= '0;
      r_level      <= '0;
      r_target     <= '0;
      r_dly        <= '0;
      r_cnt        <= '0;
      r_armed      <= 1'b0;
      r_busy       <= 1'b0;
      r_done_pend  <= 1'b0;
      r_done       <= 1'b0;
      r_abort_pend <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      // busy trails the state by one cycle so it covers the cycle of the
      // first bank change through the cycle of the last.
      r_busy  <= !force_off && (r_state != IDLE);
      // Completion and cancel events are reported in the cycle after the
      // edge on which they happen.
      r_done_pend  <= w_finish;
      r_done       <= r_done_pend;
      r_abort_pend <= force_off && (r_state != IDLE);
      r_abort      <= r_abort_pend;

      if (force_off) begin
        r_bank   <= '0;
        r_level  <= '0;
        r_target <= '0;
        r_cnt    <= '0;
      end else begin
        if (w_accept) begin
          r_target <= w_clamp;
          r_dly    <= req_dly;
        end
        if (w_do_step) begin
          r_bank  <= w_bank_step;
          r_level <= w_level_step;
        end
        if ((r_state == WAIT) && (w_state_next == WAIT)) begin
          r_cnt <= w_cnt_inc;
        end else begin
          r_cnt <= '0;
        end
      end
    end
  end

  assign bank_en   = r_bank;
  assign cur_level = r_level;
  assign busy      = r_busy;
  assign done      = r_done;
  assign abort     = r_abort;

endmodule

// File: tb/tb_drive_bank_seq.sv
module tb_drive_bank_seq;

  logic       CLK;
  logic       RESETN;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_level;
  logic [7:0] req_dly;
  logic       force_off;
  logic [7:0] bank_en;
  logic [3:0] cur_level;
  logic       busy;
  logic       done;
  logic       abort;

  int n_checks;
  int n_fail;

  drive_bank_seq #(.NBANK(8), .DLY_W(8)) dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_level (req_level),
    .req_dly   (req_dly),
    .force_off (force_off),
    .bank_en   (bank_en),
    .cur_level (cur_level),
    .busy      (busy),
    .done      (done),
    .abort     (abort)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a request for one edge; returns just after the acceptance edge (+0).
  task automatic issue(input int lvl, input int dly);
    req_valid = 1'b1;
    req_level = 4'(lvl);
    req_dly   = 8'(dly);
    tick();
    req_valid = 1'b0;
    req_level = '0;
    req_dly   = '0;
  endtask

  // Bring the block to a known level via force_off and a dly-0 ramp.
  task automatic preset(input int lvl);
    force_off = 1'b1;
    tick();
    force_off = 1'b0;
    if (lvl > 0) begin
      issue(lvl, 0);
      repeat (lvl + 1) tick();
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    #3;
    n_checks++; if (bank_en !== 8'h00) begin n_fail++; $display("FAIL reset_bank actual=%h required=%h", bank_en, 8'h00); end
    n_checks++; if (cur_level !== 4'd0) begin n_fail++; $display("FAIL reset_level actual=%0d required=0", cur_level); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready actual=%b required=0", req_ready); end
    n_checks++; if ({busy, done, abort} !== 3'b000) begin n_fail++; $display("FAIL reset_flags actual=%b required=000", {busy, done, abort}); end
    tick();
    tick();
    RESETN = 1'b1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_pre_edge actual=%b required=0", req_ready); end
    tick();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_first_edge actual=%b required=1", req_ready); end
    $display("test_reset complete");
  endtask

  task automatic test_ramp_up();
    logic [7:0] eb [9];
    logic       ebusy [9];
    logic       edone [9];
    eb    = '{8'h01, 8'h01, 8'h01, 8'h03, 8'h03, 8'h03, 8'h07, 8'h07, 8'h07};
    ebusy = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    edone = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    preset(0);
    issue(3, 2);
    n_checks++; if (bank_en !== 8'h00) begin n_fail++; $display("FAIL up_bank_c0 actual=%h required=00", bank_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL up_busy_c0 actual=%b required=0", busy); end
    for (int k = 0; k < 9; k++) begin
      tick();
      n_checks++; if (bank_en !== eb[k]) begin n_fail++; $display("FAIL up_bank_c%0d actual=%h required=%h", k + 1, bank_en, eb[k]); end
      n_checks++; if (busy !== ebusy[k]) begin n_fail++; $display("FAIL up_busy_c%0d actual=%b required=%b", k + 1, busy, ebusy[k]); end
      n_checks++; if (done !== edone[k]) begin n_fail++; $display("FAIL up_done_c%0d actual=%b required=%b", k + 1, done, edone[k]); end
      if (k == 1) begin
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL up_ready_busy actual=%b required=0", req_ready); end
      end
    end
    n_checks++; if (cur_level !== 4'd3) begin n_fail++; $display("FAIL up_level actual=%0d required=3", cur_level); end
    $display("test_ramp_up complete");
  endtask

  task automatic test_ramp_down();
    preset(5);
    n_checks++; if (bank_en !== 8'h1F) begin n_fail++; $display("FAIL dn_preset actual=%h required=1f", bank_en); end
    issue(2, 0);
    tick();
    n_checks++; if (bank_en !== 8'h0F) begin n_fail++; $display("FAIL dn_c1 actual=%h required=0f", bank_en); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL dn_busy_c1 actual=%b required=1", busy); end
    tick();
    n_checks++; if (bank_en !== 8'h07) begin n_fail++; $display("FAIL dn_c2 actual=%h required=07", bank_en); end
    tick();
    n_checks++; if (bank_en !== 8'h03) begin n_fail++; $display("FAIL dn_c3 actual=%h required=03", bank_en); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL dn_done_c3 actual=%b required=0", done); end
    tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL dn_done_c4 actual=%b required=1", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dn_busy_c4 actual=%b required=0", busy); end
    n_checks++; if (cur_level !== 4'd2) begin n_fail++; $display("FAIL dn_level actual=%0d required=2", cur_level); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL dn_done_c5 actual=%b required=0", done); end
    $display("test_ramp_down complete");
  endtask

  task automatic test_same_level();
    preset(4);
    issue(4, 3);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL same_busy_c0 actual=%b required=0", busy); end
    tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL same_done_c1 actual=%b required=1", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL same_busy_c1 actual=%b required=0", busy); end
    n_checks++; if (bank_en !== 8'h0F) begin n_fail++; $display("FAIL same_bank_c1 actual=%h required=0f", bank_en); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL same_done_c2 actual=%b required=0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL same_busy_c2 actual=%b required=0", busy); end
    n_checks++; if (bank_en !== 8'h0F) begin n_fail++; $display("FAIL same_bank_c2 actual=%h required=0f", bank_en); end
    $display("test_same_level complete");
  endtask

  task automatic test_clamp();
    preset(0);
    issue(12, 0);
    repeat (7) tick();
    n_checks++; if (bank_en !== 8'h7F) begin n_fail++; $display("FAIL clamp_c7 actual=%h required=7f", bank_en); end
    tick();
    n_checks++; if (bank_en !== 8'hFF) begin n_fail++; $display("FAIL clamp_c8 actual=%h required=ff", bank_en); end
    n_checks++; if (cur_level !== 4'd8) begin n_fail++; $display("FAIL clamp_level actual=%0d required=8", cur_level); end
    tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL clamp_done actual=%b required=1", done); end
    n_checks++; if (bank_en !== 8'hFF) begin n_fail++; $display("FAIL clamp_hold actual=%h required=ff", bank_en); end
    tick();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL clamp_ready actual=%b required=1", req_ready); end
    $display("test_clamp complete");
  endtask

  task automatic test_force_abort();
    preset(0);
    issue(5, 3);
    repeat (9) tick();
    n_checks++; if (bank_en !== 8'h07) begin n_fail++; $display("FAIL fo_pre_bank actual=%h required=07", bank_en); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fo_pre_busy actual=%b required=1", busy); end
    tick();
    force_off = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL fo_ready_low actual=%b required=0", req_ready); end
    tick();
    n_checks++; if (bank_en !== 8'h00) begin n_fail++; $display("FAIL fo_bank actual=%h required=00", bank_en); end
    n_checks++; if (cur_level !== 4'd0) begin n_fail++; $display("FAIL fo_level actual=%0d required=0", cur_level); end
    n_checks++; if (abort !== 1'b0) begin n_fail++; $display("FAIL fo_abort_early actual=%b required=0", abort); end
    force_off = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL fo_ready_after actual=%b required=1", req_ready); end
    tick();
    n_checks++; if (abort !== 1'b1) begin n_fail++; $display("FAIL fo_abort actual=%b required=1", abort); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL fo_done actual=%b required=0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fo_busy actual=%b required=0", busy); end
    tick();
    n_checks++; if ({abort, done} !== 2'b00) begin n_fail++; $display("FAIL fo_pulse_end actual=%b required=00", {abort, done}); end
    $display("test_force_abort complete");
  endtask

  task automatic test_back_to_back();
    preset(0);
    issue(4, 1);
    tick();
    n_checks++; if (bank_en !== 8'h01) begin n_fail++; $display("FAIL b2b_c1 actual=%h required=01", bank_en); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_busy actual=%b required=0", req_ready); end
    req_valid = 1'b1;
    req_level = 4'd1;
    req_dly   = 8'd0;
    tick();
    req_valid = 1'b0;
    req_level = '0;
    n_checks++; if (bank_en !== 8'h01) begin n_fail++; $display("FAIL b2b_c2 actual=%h required=01", bank_en); end
    tick();
    n_checks++; if (bank_en !== 8'h03) begin n_fail++; $display("FAIL b2b_c3 actual=%h required=03", bank_en); end
    tick();
    n_checks++; if (bank_en !== 8'h03) begin n_fail++; $display("FAIL b2b_c4 actual=%h required=03", bank_en); end
    repeat (3) tick();
    n_checks++; if (bank_en !== 8'h0F) begin n_fail++; $display("FAIL b2b_c7 actual=%h required=0f", bank_en); end
    tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done actual=%b required=1", done); end
    n_checks++; if (cur_level !== 4'd4) begin n_fail++; $display("FAIL b2b_level actual=%0d required=4", cur_level); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_idle actual=%b required=1", req_ready); end
    issue(2, 0);
    tick();
    n_checks++; if (bank_en !== 8'h07) begin n_fail++; $display("FAIL b2b2_c1 actual=%h required=07", bank_en); end
    tick();
    n_checks++; if (bank_en !== 8'h03) begin n_fail++; $display("FAIL b2b2_c2 actual=%h required=03", bank_en); end
    tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b2_done actual=%b required=1", done); end
    $display("test_back_to_back complete");
  endtask

  task automatic test_reset_mid_ramp();
    preset(0);
    issue(8, 1);
    repeat (11) tick();
    n_checks++; if (bank_en !== 8'h3F) begin n_fail++; $display("FAIL rst_pre_bank actual=%h required=3f", bank_en); end
    #2;
    RESETN = 1'b0;
    #1;
    n_checks++; if (bank_en !== 8'h00) begin n_fail++; $display("FAIL rst_async_bank actual=%h required=00", bank_en); end
    n_checks++; if (cur_level !== 4'd0) begin n_fail++; $display("FAIL rst_async_level actual=%0d required=0", cur_level); end
    n_checks++; if ({busy, done, abort, req_ready} !== 4'b0000) begin n_fail++; $display("FAIL rst_async_flags actual=%b required=0000", {busy, done, abort, req_ready}); end
    repeat (3) tick();
    n_checks++; if ({done, abort} !== 2'b00) begin n_fail++; $display("FAIL rst_hold_pulses actual=%b required=00", {done, abort}); end
    RESETN = 1'b1;
    tick();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready actual=%b required=1", req_ready); end
    n_checks++; if ({done, abort, busy} !== 3'b000) begin n_fail++; $display("FAIL rst_post_pulses actual=%b required=000", {done, abort, busy}); end
    n_checks++; if (bank_en !== 8'h00) begin n_fail++; $display("FAIL rst_post_bank actual=%h required=00", bank_en); end
    $display("test_reset_mid_ramp complete");
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    RESETN    = 1'b0;
    req_valid = 1'b0;
    req_level = '0;
    req_dly   = '0;
    force_off = 1'b0;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_same_level();
    test_clamp();
    test_force_abort();
    test_back_to_back();
    test_reset_mid_ramp();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
